// File: rtl/hr_pkg.sv
// Shared definitions for the heart-rate front end: tick rate, beat FSM states
// and default millisecond limits reused by the interval and arrhythmia stages.
package hr_pkg;

    localparam int TICK_HZ = 1000;

    localparam int DEBOUNCE_MS_DEF   = 8;
    localparam int REFRACTORY_MS_DEF = 250;
    localparam int ASYSTOLE_MS_DEF   = 3000;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        READY      = 2'd1,
        REFRACT    = 2'd2
    } beat_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_debouncer.sv
// Synchronises the raw heartbeat pin, debounces it on the ms tick and emits a
// registered single-cycle strobe one clk after the debounced level rises.
module pulse_debouncer
    import hr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ms_tick_i,
    input  logic enable_i,
    input  logic pulse_raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q;
    logic                   rise_q;

    // The synchroniser keeps sampling while disabled so re-enabling sees a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_raw_i};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!enable_i) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (ms_tick_i) begin
            if (sync_bit == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= enable_i & level_q;
            rise_q      <= enable_i & level_q & ~level_dly_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/beat_pulse_conditioner.sv
// Beat acceptance stage: turns debounced rising edges into single-cycle beat
// strobes, enforcing the refractory lockout and tracking asystole.
module beat_pulse_conditioner
    import hr_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
    parameter int REFRACTORY_MS = REFRACTORY_MS_DEF,
    parameter int ASYSTOLE_MS   = ASYSTOLE_MS_DEF,
    parameter int CNT_W         = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ms_tick,
    input  logic       enable,
    input  logic       pulse_raw,
    output logic       beat_pulse,
    output logic       pulse_level,
    output logic       refractory,
    output logic       asystole_flag,
    output logic [7:0] rejected_count
);

    localparam logic [CNT_W-1:0] REFR_LAST = CNT_W'(REFRACTORY_MS - 1);
    localparam logic [CNT_W-1:0] ASYS_MAX  = CNT_W'(ASYSTOLE_MS);

    beat_state_e      state_q, state_d;
    logic [CNT_W-1:0] refr_cnt_q, refr_cnt_d;
    logic [CNT_W-1:0] asys_cnt_q, asys_cnt_d;
    logic [7:0]       rej_cnt_q, rej_cnt_d;
    logic             beat_q, beat_d;
    logic             asys_flag_q, asys_flag_d;
    logic             rise;
    logic             accept;

    pulse_debouncer #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .ms_tick_i   (ms_tick),
        .enable_i    (enable),
        .pulse_raw_i (pulse_raw),
        .level_o     (pulse_level),
        .rise_o      (rise)
    );

    always_comb begin
        state_d    = state_q;
        refr_cnt_d = refr_cnt_q;
        asys_cnt_d = asys_cnt_q;
        rej_cnt_d  = rej_cnt_q;
        beat_d     = 1'b0;
        accept     = 1'b0;

        if (!enable) begin
            state_d    = WAIT_FIRST;
            refr_cnt_d = '0;
            asys_cnt_d = '0;
        end else begin
            case (state_q)
                WAIT_FIRST: accept = rise;
                READY:      accept = rise;
                REFRACT: begin
                    // A rise coinciding with expiry still sees the lockout.
                    if (rise) begin
                        rej_cnt_d = sat_inc8(rej_cnt_q);
                    end
                    if (ms_tick) begin
                        if (refr_cnt_q == REFR_LAST) begin
                            state_d    = READY;
                            refr_cnt_d = '0;
                        end else begin
                            refr_cnt_d = refr_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = WAIT_FIRST;
            endcase

            if ((state_q != WAIT_FIRST) && ms_tick && (asys_cnt_q != ASYS_MAX)) begin
                asys_cnt_d = asys_cnt_q + CNT_W'(1);
            end

            if (accept) begin
                beat_d     = 1'b1;
                state_d    = REFRACT;
                refr_cnt_d = '0;
                asys_cnt_d = '0;
            end
        end

        // Taken from the next count so the flag drops on the beat cycle itself.
        asys_flag_d = (asys_cnt_d == ASYS_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_FIRST;
            refr_cnt_q  <= '0;
            asys_cnt_q  <= '0;
            rej_cnt_q   <= '0;
            beat_q      <= 1'b0;
            asys_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            refr_cnt_q  <= refr_cnt_d;
            asys_cnt_q  <= asys_cnt_d;
            rej_cnt_q   <= rej_cnt_d;
            beat_q      <= beat_d;
            asys_flag_q <= asys_flag_d;
        end
    end

    assign beat_pulse     = beat_q;
    assign refractory     = (state_q == REFRACT);
    assign asystole_flag  = asys_flag_q;
    assign rejected_count = rej_cnt_q;

endmodule

// File: doc/beat_pulse_conditioner.md
Name: beat_pulse_conditioner

Overview:
Front-end stage directly upstream of the RR-interval detector. Conditions the raw heartbeat input: synchronises it, debounces it on the 1 kHz millisecond tick, detects rising edges, and enforces a physiological refractory lockout. Emits one clean single-cycle beat strobe per accepted beat. Also reports rejected (too-early) edges and flags asystole (no beat for too long).

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (>=2)
DEBOUNCE_MS, 8, consecutive ms ticks of a new level before the debounced level changes (>=1)
REFRACTORY_MS, 250, ms after an accepted beat during which rising edges are rejected (>=1)
ASYSTOLE_MS, 3000, ms without an accepted beat before asystole_flag asserts
CNT_W, 12, width of the refractory and asystole ms counters (must hold ASYSTOLE_MS)

Ports:
clk  in  1  design clock
rst_n  in  1  reset, asynchronous assert, active-low
ms_tick  in  1  single-cycle 1 kHz enable from the clock divider
enable  in  1  conditioning enable; low = hold idle
pulse_raw  in  1  asynchronous heartbeat pulse pin
beat_pulse  out  1  one clk-cycle strobe per accepted beat
pulse_level  out  1  debounced pulse level
refractory  out  1  high while in lockout window
asystole_flag  out  1  high when ASYSTOLE_MS elapsed since last accepted beat
rejected_count  out  8  saturating count of edges rejected during refractory

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All outputs, synchroniser flops, counters and state return to 0 / WAIT_FIRST on reset, including mid-operation.
- Synchroniser: SYNC_STAGES flops on clk, always running, even when enable is low.
- Debounce: counter advances only on ms_tick cycles where sync output != pulse_level. It clears on any ms_tick cycle where they are equal.
  - When a mismatch tick occurs with the counter at DEBOUNCE_MS-1, pulse_level toggles and the counter clears.
  - Net effect: DEBOUNCE_MS consecutive mismatching ticks are required for a change.
- Edge: rise = pulse_level goes 0->1, detected from pulse_level and its 1-cycle delayed copy.
- FSM states and transitions:
  - WAIT_FIRST: on rise -> accept beat -> REFRACT. Asystole timer is not running.
  - REFRACT: refractory=1. The ms counter increments on ms_tick. After REFRACTORY_MS ticks -> READY, counter cleared. A rise here is rejected: rejected_count+1, saturating at 255, no beat_pulse.
  - READY: on rise -> accept -> REFRACT.
  - If a rise and refractory expiry happen in the same cycle, the rise is evaluated against the current state (REFRACT), so it is rejected.
- Accept: beat_pulse=1 for exactly the cycle after the rise is detected, which makes it registered. Fixed latency from the pulse_level rise to beat_pulse is 2 clk. The refractory counter clears and the asystole counter clears.
- Asystole counter: runs in REFRACT/READY and increments on ms_tick. It saturates at ASYSTOLE_MS. asystole_flag = (counter == ASYSTOLE_MS), registered. The flag clears on the cycle beat_pulse asserts.
- enable low:
  - Force WAIT_FIRST and clear the debounce, refractory and asystole counters.
  - pulse_level tracks 0, beat_pulse=0, asystole_flag=0.
  - rejected_count holds its value.
  - Re-enabling starts from WAIT_FIRST.
- ms_tick high for more than 1 cycle is an illegal stimulus; behaviour is undefined.

Decomposition:
- Shared package (hr_pkg): the 1 kHz tick rate constant, the FSM state enum {WAIT_FIRST, READY, REFRACT}, and the default ms limits (debounce, refractory 250, asystole 3000). These are reused by the interval and arrhythmia stages.
- Natural sub-module: pulse_debouncer, covering the synchroniser plus the debounce counter. It outputs pulse_level and a rise strobe.

Test Plan:
- Reset mid-refractory: assert rst_n=0 asynchronously -> all outputs 0 immediately. After release, the next clean rise gives beat_pulse with no rejection.
- Glitch rejection: pulse_raw high for 5 ms ticks, then low -> pulse_level stays 0, no beat_pulse. High for 8 ticks -> pulse_level=1, beat_pulse exactly 2 clk later, width 1 clk.
- Refractory: beat accepted, second clean rise 100 ms later -> no beat_pulse, rejected_count=1, refractory=1. A rise at 300 ms -> beat_pulse, refractory re-asserts.
- Boundary: rise landing on the exact tick where 250 ms expires -> rejected. A rise 1 tick later -> accepted.
- Asystole: one beat, then silence -> asystole_flag=1 after 3000 ticks. The next beat clears the flag on the beat_pulse cycle. No flag before the first beat even after 5000 ticks.
- Saturation/enable: 300 early edges -> rejected_count=255. Drop enable -> state WAIT_FIRST, flags 0, count holds 255.
